// File: rtl/ptc_duty_sequencer.sv
// ptc_duty_sequencer
// Autonomous bus master for the PTC register port. On start it resets the
// counter, loads LRC, writes the first HRC table value and enables the PTC.
// After that it steps through a table of HRC (duty) values, holding each one
// for a programmable number of PWM periods.
//
// Build option: define PTC_SEQ_LOOP_EN to honour control bit [3] (loop back
// to step 0 after the last step). Without it the bit is ignored and every
// run ends with a CTRL=0 write, DONE and irq.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   cfg_we/cfg_addr/cfg_wdata   host config: 0..DEPTH-1 table, 8 LRC, 9 control
//   start, abort                sequence control pulses
//   period_tick                 one pulse per completed PTC period
//   ptc_address/ptc_wdata       PTC register write address/data (registered)
//   ptc_write_n                 2'b10 = 32-bit write, 2'b11 = idle
//   busy, done, step_idx, irq   status
module ptc_duty_sequencer #(
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        start,
    input  logic        abort,
    input  logic        period_tick,
    output logic [5:0]  ptc_address,
    output logic [31:0] ptc_wdata,
    output logic [1:0]  ptc_write_n,
    output logic        busy,
    output logic        done,
    output logic [2:0]  step_idx,
    output logic        irq
);

    localparam logic [2:0] LAST_MAX = 3'(DEPTH - 1);
    localparam logic [3:0] A_LRC    = 4'd8;
    localparam logic [3:0] A_CTRL   = 4'd9;
    localparam logic [5:0] R_HRC    = 6'h04;
    localparam logic [5:0] R_LRC    = 6'h08;
    localparam logic [5:0] R_CTRL   = 6'h0C;

    typedef enum logic [3:0] {
        S_IDLE, S_RST, S_LRC, S_HRC, S_EN, S_WAIT, S_FIN, S_DONE, S_ABT
    } state_t;

    state_t        state_q, state_d;
    // Table storage is always 8 entries so a 3-bit step indexes it cleanly;
    // only the first DEPTH entries are writable.
    logic [CW-1:0] tbl_hrc [8];
    logic [7:0]    tbl_rep [8];
    logic [CW-1:0] lrc_q;
    logic [2:0]    last_q, last_eff, step_d;
    logic          loop_en;
    logic [7:0]    rep_q, rep_d;
    logic          first_q, first_d;
    logic [5:0]    addr_d;
    logic [31:0]   wdata_d;
    logic [1:0]    wn_d;
    logic          done_d;
    logic          unused_cfg;

    assign unused_cfg = ^cfg_wdata;

`ifdef PTC_SEQ_LOOP_EN
    logic loop_q;
    assign loop_en = loop_q;
`else
    assign loop_en = 1'b0;
`endif

    assign last_eff = (last_q > LAST_MAX) ? LAST_MAX : last_q;

    // Host config. Table entries stay writable during a run; LRC and control
    // are frozen while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                tbl_hrc[i] <= '0;
                tbl_rep[i] <= '0;
            end
            lrc_q  <= '0;
            last_q <= '0;
`ifdef PTC_SEQ_LOOP_EN
            loop_q <= 1'b0;
`endif
        end else if (cfg_we) begin
            if (cfg_addr < 4'(DEPTH)) begin
                tbl_hrc[cfg_addr[2:0]] <= cfg_wdata[CW-1:0];
                tbl_rep[cfg_addr[2:0]] <= cfg_wdata[23:16];
            end else if (!busy && cfg_addr == A_LRC) begin
                lrc_q <= cfg_wdata[CW-1:0];
            end else if (!busy && cfg_addr == A_CTRL) begin
                last_q <= cfg_wdata[2:0];
`ifdef PTC_SEQ_LOOP_EN
                loop_q <= cfg_wdata[3];
`endif
            end
        end
    end

    // Next state plus next-cycle outputs, decoded from state_d so that every
    // output is a flop.
    always_comb begin
        state_d = state_q;
        step_d  = step_idx;
        rep_d   = rep_q;
        first_d = first_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (!abort && start) begin
                    state_d = S_RST;
                    first_d = 1'b1;
                end
            end
            S_RST: state_d = abort ? S_ABT : S_LRC;
            S_LRC: begin
                if (abort) state_d = S_ABT;
                else begin
                    state_d = S_HRC;
                    step_d  = '0;
                end
            end
            S_HRC: begin
                first_d = 1'b0;
                if (abort)        state_d = S_ABT;
                else if (first_q) state_d = S_EN;
                else              state_d = S_WAIT;
            end
            S_EN:  state_d = abort ? S_ABT : S_WAIT;
            S_WAIT: begin
                if (abort) state_d = S_ABT;
                else if (period_tick) begin
                    if (rep_q > 8'd1) rep_d = rep_q - 8'd1;
                    else if (step_idx < last_eff) begin
                        step_d  = step_idx + 3'd1;
                        state_d = S_HRC;
                    end else if (loop_en) begin
                        step_d  = '0;
                        state_d = S_HRC;
                    end else state_d = S_FIN;
                end
            end
            S_FIN:   state_d = abort ? S_ABT : S_DONE;
            S_ABT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Repeat count is sampled from the table at the HRC write, so live
        // table edits apply from that step's next visit. A count of 0 means 1.
        if (state_d == S_HRC)
            rep_d = (tbl_rep[step_d] == 8'd0) ? 8'd1 : tbl_rep[step_d];

        wn_d    = 2'b11;
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            S_RST: begin wn_d = 2'b10; addr_d = R_CTRL; wdata_d = 32'h80; end
            S_LRC: begin wn_d = 2'b10; addr_d = R_LRC;  wdata_d = 32'(lrc_q); end
            S_HRC: begin wn_d = 2'b10; addr_d = R_HRC;  wdata_d = 32'(tbl_hrc[step_d]); end
            S_EN:  begin wn_d = 2'b10; addr_d = R_CTRL; wdata_d = 32'h29; end
            S_FIN, S_ABT: begin wn_d = 2'b10; addr_d = R_CTRL; end
            default: ;
        endcase

        done_d = done;
        if (state_d == S_RST)  done_d = 1'b0;
        if (state_d == S_DONE) done_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rep_q       <= '0;
            first_q     <= 1'b0;
            step_idx    <= '0;
            ptc_write_n <= 2'b11;
            ptc_address <= '0;
            ptc_wdata   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            irq         <= 1'b0;
        end else begin
            state_q     <= state_d;
            rep_q       <= rep_d;
            first_q     <= first_d;
            step_idx    <= step_d;
            ptc_write_n <= wn_d;
            ptc_address <= addr_d;
            ptc_wdata   <= wdata_d;
            busy        <= (state_d != S_IDLE) && (state_d != S_DONE);
            done        <= done_d;
            irq         <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_ptc_duty_sequencer.sv
// Self-checking bench for ptc_duty_sequencer (DEPTH = 4). A transaction-queue
// reference model predicts every output each cycle; directed scenarios follow
// the feature list, then a randomized phase exercises mixed traffic.
module tb_ptc_duty_sequencer;
    localparam int DEPTH = 4;
    localparam int CW    = 16;

    localparam int K_NONE = 0, K_RST = 1, K_LRC = 2, K_HRC = 3, K_EN = 4,
                   K_FIN = 5, K_ABT = 6, K_DONE = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        start = 1'b0, abort = 1'b0, period_tick = 1'b0;
    logic [5:0]  ptc_address;
    logic [31:0] ptc_wdata;
    logic [1:0]  ptc_write_n;
    logic        busy, done, irq;
    logic [2:0]  step_idx;

    int n_chk = 0;
    int n_err = 0;

    ptc_duty_sequencer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .start(start), .abort(abort),
        .period_tick(period_tick), .ptc_address(ptc_address),
        .ptc_wdata(ptc_wdata), .ptc_write_n(ptc_write_n), .busy(busy),
        .done(done), .step_idx(step_idx), .irq(irq)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int q[$];          // pending writes: kind + 256*step
    int cur;           // what is shown this cycle
    bit act;
    int m_step, m_rem, m_lrc, m_last;
    bit m_done, m_loop;
    int m_hrc [DEPTH];
    int m_rep [DEPTH];
    int e_wn, e_addr, e_data, e_busy, e_done, e_irq, e_step;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur = K_NONE; act = 0;
        m_step = 0; m_rem = 0; m_lrc = 0; m_last = 0; m_done = 0; m_loop = 0;
        for (int i = 0; i < DEPTH; i++) begin m_hrc[i] = 0; m_rep[i] = 0; end
        e_wn = 3; e_addr = 0; e_data = 0; e_busy = 0; e_done = 0; e_irq = 0; e_step = 0;
    endtask

    // Advance the model across one clock edge given the inputs sampled there.
    task automatic model_step(input bit st, input bit ab, input bit tk, input bit we,
                              input logic [3:0] a, input logic [31:0] d);
        bit busy_now;
        int nxt, e, lastc;
        busy_now = (e_busy != 0);
        nxt = K_NONE;
        lastc = (m_last > DEPTH - 1) ? DEPTH - 1 : m_last;
        if (busy_now) begin
            if (cur == K_ABT) act = 0;
            else if (ab) begin q.delete(); q.push_back(K_ABT); end
            else if (cur == K_FIN) begin act = 0; nxt = K_DONE; end
            else if (cur == K_NONE && q.size() == 0 && tk) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_step < lastc) q.push_back(K_HRC + 256 * (m_step + 1));
                    else if (m_loop)    q.push_back(K_HRC);
                    else                q.push_back(K_FIN);
                end
            end
        end else if (!ab && st) begin
            m_done = 0; act = 1;
            q.push_back(K_RST); q.push_back(K_LRC); q.push_back(K_HRC); q.push_back(K_EN);
        end
        if (nxt == K_NONE && q.size() > 0) begin
            e = q.pop_front();
            nxt = e % 256;
            if (nxt == K_HRC) begin
                m_step = e / 256;
                m_rem  = (m_rep[m_step] == 0) ? 1 : m_rep[m_step];
            end
        end
        if (nxt == K_DONE) m_done = 1;
        e_wn = 3; e_addr = 0; e_data = 0;
        case (nxt)
            K_RST: begin e_wn = 2; e_addr = 'h0C; e_data = 'h80; end
            K_LRC: begin e_wn = 2; e_addr = 'h08; e_data = m_lrc; end
            K_HRC: begin e_wn = 2; e_addr = 'h04; e_data = m_hrc[m_step]; end
            K_EN:  begin e_wn = 2; e_addr = 'h0C; e_data = 'h29; end
            K_FIN, K_ABT: begin e_wn = 2; e_addr = 'h0C; e_data = 0; end
            default: ;
        endcase
        e_busy = act ? 1 : 0;
        e_irq  = (nxt == K_DONE) ? 1 : 0;
        e_done = m_done ? 1 : 0;
        e_step = m_step;
        cur = nxt;
        if (we) begin
            if (int'(a) < DEPTH) begin
                m_hrc[a] = int'(d[15:0]);
                m_rep[a] = int'(d[23:16]);
            end else if (!busy_now && a == 4'd8) m_lrc = int'(d[15:0]);
            else if (!busy_now && a == 4'd9) begin
                m_last = int'(d[2:0]);
`ifdef PTC_SEQ_LOOP_EN
                m_loop = d[3];
`endif
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic cyc(input bit st, input bit ab, input bit tk, input bit we,
                       input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        chk("wn",    32'(ptc_write_n), 32'(e_wn));
        chk("addr",  32'(ptc_address), 32'(e_addr));
        chk("wdata", ptc_wdata,        32'(e_data));
        chk("busy",  32'(busy),        32'(e_busy));
        chk("done",  32'(done),        32'(e_done));
        chk("irq",   32'(irq),         32'(e_irq));
        chk("step",  32'(step_idx),    32'(e_step));
        start = st; abort = ab; period_tick = tk;
        cfg_we = we; cfg_addr = a; cfg_wdata = d;
        model_step(st, ab, tk, we, a, d);
    endtask

    task automatic idle();                  cyc(0, 0, 0, 0, 4'd0, 32'd0); endtask
    task automatic tick();                  cyc(0, 0, 1, 0, 4'd0, 32'd0); endtask
    task automatic cfg(input logic [3:0] a, input logic [31:0] d); cyc(0, 0, 0, 1, a, d); endtask
    task automatic go();                    cyc(1, 0, 0, 0, 4'd0, 32'd0); endtask

    function automatic logic [31:0] ent(input int rep, input int hrc);
        return {8'h00, 8'(rep), 16'(hrc)};
    endfunction

    // Asynchronous reset mid-cycle; outputs must drop at once.
    task automatic do_reset();
        start = 0; abort = 0; period_tick = 0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_async_wn",   32'(ptc_write_n), 32'd3);
        chk("rst_async_busy", 32'(busy),        32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        model_step(0, 0, 0, 0, 4'd0, 32'd0);
    endtask

    task automatic prologue();
        go(); idle(); idle(); idle(); idle();
    endtask

    initial begin
        bit st, ab, tk, we;
        logic [3:0] a;
        logic [31:0] d;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_step(0, 0, 0, 0, 4'd0, 32'd0);

        // Basic run: LRC=100, 25 x1, 75 x2, last=1
        cfg(4'd8, 32'd100); cfg(4'd0, ent(1, 25)); cfg(4'd1, ent(2, 75)); cfg(4'd9, 32'd1);
        go();
        idle(); chk("s1_rst_addr", 32'(ptc_address), 32'h0C); chk("s1_rst_data", ptc_wdata, 32'h80);
        idle(); chk("s1_lrc_addr", 32'(ptc_address), 32'h08); chk("s1_lrc_data", ptc_wdata, 32'd100);
        idle(); chk("s1_hrc_addr", 32'(ptc_address), 32'h04); chk("s1_hrc_data", ptc_wdata, 32'd25);
        idle(); chk("s1_en_addr",  32'(ptc_address), 32'h0C); chk("s1_en_data",  ptc_wdata, 32'h29);
        tick(); chk("s1_wait_wn", 32'(ptc_write_n), 32'd3);
        idle(); chk("s1_hrc2_data", ptc_wdata, 32'd75); chk("s1_hrc2_step", 32'(step_idx), 32'd1);
        tick();
        tick(); chk("s1_tick2_nowrite", 32'(ptc_write_n), 32'd3);
        idle(); chk("s1_fin_data", ptc_wdata, 32'h0); chk("s1_fin_wn", 32'(ptc_write_n), 32'd2);
        idle(); chk("s1_irq", 32'(irq), 32'd1); chk("s1_done", 32'(done), 32'd1); chk("s1_busy", 32'(busy), 32'd0);
        idle(); chk("s1_irq_pulse", 32'(irq), 32'd0); chk("s1_done_hold", 32'(done), 32'd1);

        // Loop bit set
        cfg(4'd9, 32'd9);
        prologue();
        tick(); idle(); tick(); tick();
        idle();
`ifdef PTC_SEQ_LOOP_EN
        chk("loop_hrc_data", ptc_wdata, 32'd25); chk("loop_step", 32'(step_idx), 32'd0);
        chk("loop_busy", 32'(busy), 32'd1);
`else
        chk("noloop_fin_addr", 32'(ptc_address), 32'h0C); chk("noloop_fin_data", ptc_wdata, 32'h0);
`endif
        cyc(0, 1, 0, 0, 4'd0, 32'd0); idle(); idle(); idle();

        // Abort together with the exhausting tick
        cfg(4'd9, 32'd1);
        prologue();
        cyc(0, 1, 1, 0, 4'd0, 32'd0);
        idle(); chk("abt_addr", 32'(ptc_address), 32'h0C); chk("abt_data", ptc_wdata, 32'h0);
        chk("abt_step", 32'(step_idx), 32'd0);
        idle(); chk("abt_busy", 32'(busy), 32'd0); chk("abt_done", 32'(done), 32'd0); chk("abt_irq", 32'(irq), 32'd0);

        // Repeat 0 and last clamped to DEPTH-1
        for (int i = 0; i < DEPTH; i++) cfg(4'(i), ent(0, 10 * (i + 1)));
        cfg(4'd9, 32'd7);
        prologue();
        for (int i = 0; i < DEPTH - 1; i++) begin
            tick(); idle();
            chk("clamp_step", 32'(step_idx), 32'(i + 1));
        end
        tick(); idle();
        chk("clamp_fin_addr", 32'(ptc_address), 32'h0C); chk("clamp_fin_step", 32'(step_idx), 32'd3);
        idle(); chk("clamp_irq", 32'(irq), 32'd1);

        // Reset during WAIT, then start with LRC cleared
        prologue(); idle();
        do_reset();
        go(); idle();
        idle(); chk("post_rst_lrc_addr", 32'(ptc_address), 32'h08); chk("post_rst_lrc_data", ptc_wdata, 32'h0);
        idle(); idle(); idle();

        // Random traffic
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 999) < 3) do_reset();
            else begin
                st = ($urandom_range(0, 19) == 0);
                ab = ($urandom_range(0, 59) == 0);
                tk = ($urandom_range(0, 2) == 0);
                we = ($urandom_range(0, 7) == 0);
                a  = 4'($urandom_range(0, 15));
                if (a == 4'd9) d = 32'($urandom_range(0, 15));
                else d = ent($urandom_range(0, 3), $urandom_range(0, 65535));
                cyc(st, ab, tk, we, a, d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/ptc_duty_sequencer.md
# ptc_duty_sequencer

Bus-master sequencer that drives the PWM/Timer/Counter (PTC) peripheral's register write port autonomously. It loads the period (LRC), walks a table of duty values (HRC) with a per-step repeat count, and advances one step per completed PWM period. It sits between a host configuration port and the PTC register interface, so duty-cycle profiles run with no per-period CPU writes.

## Interface
- DEPTH, 8, number of table steps (2..8)
- CW, 16, PTC counter width; HRC/LRC field width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_we  in  1  host config write strobe
- cfg_addr  in  4  0..DEPTH-1 = table entry, 8 = LRC, 9 = control
- cfg_wdata  in  32  config write data
- start  in  1  start-sequence pulse
- abort  in  1  abort-sequence pulse
- period_tick  in  1  one-cycle pulse per completed PTC period (LRC match)
- ptc_address  out  6  PTC register address
- ptc_wdata  out  32  PTC write data
- ptc_write_n  out  2  2'b10 = 32-bit write, 2'b11 = idle
- busy  out  1  sequence active
- done  out  1  last sequence completed normally (level)
- step_idx  out  3  current table step
- irq  out  1  one-cycle pulse on normal completion

## Operation
- Table entry: [CW-1:0] HRC value, [23:16] repeat count in periods (0 treated as 1). LRC reg: [CW-1:0]. Control: [2:0] last step (values > DEPTH-1 clamp to DEPTH-1), [3] loop.
- PTC map: CNTR 0x00, HRC 0x04, LRC 0x08, CTRL 0x0C. CTRL bits: EN 0, OE 3, INTE 5, CNTRRST 7.
- FSM: IDLE -> W_RST (CTRL = 0x80) -> W_LRC (LRC) -> W_HRC (table[step]) -> W_EN (CTRL = 0x29, first entry only) -> WAIT.
- In WAIT, each period_tick decrements the repeat counter. The tick that exhausts it does one of the following:
  - step < last: step+1, W_HRC, WAIT; the repeat counter reloads.
  - step == last with loop set: step = 0, W_HRC, WAIT.
  - Otherwise: W_FIN (CTRL = 0x00) -> DONE -> IDLE.
- W_EN is entered only on the first W_HRC after start. Later W_HRC states return straight to WAIT.
- abort in any non-IDLE state: any write in flight completes, then W_ABT (CTRL = 0x00) -> IDLE. done stays 0 and irq does not fire.
- Boundary rules:
  - abort and period_tick in the same cycle: abort wins.
  - start while busy: ignored. start and abort together in IDLE: abort wins and start is ignored.
  - period_tick outside WAIT: ignored.
  - Table writes while busy are accepted and take effect at the next W_HRC of that step.
  - LRC and control writes while busy are ignored.
- Reset values: table, LRC and control = 0; step_idx = 0; ptc_write_n = 2'b11; ptc_address = 0; ptc_wdata = 0; busy = 0; done = 0; irq = 0. Reset mid-sequence returns to IDLE immediately with no PTC write.

## Timing
- All outputs are registered.
- Each W_* state lasts exactly one cycle with ptc_write_n = 2'b10. In every other cycle, ptc_write_n = 2'b11 and ptc_address/ptc_wdata = 0.
- start sampled at cycle N -> W_RST write at N+1, W_LRC at N+2, W_HRC at N+3, W_EN at N+4, WAIT from N+5.
- Exhausting tick at cycle T -> W_HRC write at T+1, WAIT at T+2.
- busy rises at N+1 and falls in the cycle after W_FIN or W_ABT.
- DONE lasts one cycle, with irq = 1 in that cycle. done goes high in the DONE cycle and stays high until the next accepted start.
- step_idx updates in the W_HRC cycle.

## Configuration
- PTC_SEQ_LOOP_EN defined: control bit [3] selects looping as described in Operation.
- PTC_SEQ_LOOP_EN undefined: control bit [3] is ignored and reads as 0. The sequence always ends in W_FIN/DONE after the last step.

## Test plan
- LRC = 100, table[0] = 25 rep 1, table[1] = 75 rep 2, last = 1, start -> writes (0x0C,0x80), (0x08,100), (0x04,25), (0x0C,0x29) on consecutive cycles.
- Same setup, continue with ticks -> after tick 1, write (0x04,75) and step_idx = 1. Tick 2 gives no write. After tick 3, write (0x0C,0x00), irq pulse, done = 1, busy = 0.
- Loop = 1 with PTC_SEQ_LOOP_EN, run past the last step -> write (0x04,25) and step_idx = 0, busy stays 1. Without the macro -> the run ends in DONE.
- abort asserted in the same cycle as the exhausting tick in WAIT -> only write (0x0C,0x00), no HRC write, done = 0, irq = 0.
- Repeat count 0 -> the step advances after 1 tick. Last = 7 with DEPTH = 4 -> the run ends after step 3.
- rst_n low during WAIT -> ptc_write_n = 2'b11 and busy = 0 immediately. A start after reset with LRC = 0 sends (0x08,0).
